// File: rtl/loc_sram_drain_pkg.sv
// loc_drain_pkg: shared state encoding, default geometry and entry layout for the location SRAM drain
package loc_drain_pkg;
  localparam int ADDR_SPACE_DEF = 4;
  localparam int BW_DEF = 5;
  localparam int D_DEF = 256;
  typedef enum logic [2:0] {IDLE, RD, CAP, SCAN, WB, DONE} state_e;
  // entry 0 sits in the most significant field of a row
  function automatic int field_off(input int idx, input int d, input int bw);
    return (d - 1 - idx) * bw;
  endfunction
endpackage

// File: rtl/loc_sram_drain_field_mux.sv
// loc_field_mux: row buffer with idx-selected {valid, payload} extraction, looking through a row being loaded
module loc_field_mux
  import loc_drain_pkg::*;
#(
  parameter int BW = BW_DEF,
  parameter int D = D_DEF,
  localparam int IW = $clog2(D)
) (
  input  logic            clk,
  input  logic            load,
  input  logic [D*BW-1:0] wdata,
  input  logic [IW-1:0]   sel,
  output logic            valid,
  output logic [BW-2:0]   payload
);
  logic [D*BW-1:0] row_q, row_d;
  logic [BW-1:0] fld;
  // next buffer contents; extraction uses them so a freshly captured row is visible immediately
  always_comb begin
    row_d = load ? wdata : row_q;
    fld = row_d[field_off(int'(sel), D, BW) +: BW];
  end
  // row buffer register
  always_ff @(posedge clk) row_q <= row_d;
  assign valid = fld[BW-1];
  assign payload = fld[BW-2:0];
endmodule

// File: rtl/loc_sram_drain.sv
// loc_sram_drain: drains valid entries of the location SRAM onto a stream; LOC_DRAIN_CLEAR_EN adds the clearing write-back
module loc_sram_drain
  import loc_drain_pkg::*;
#(
  parameter int ADDR_SPACE = ADDR_SPACE_DEF,
  parameter int BW = BW_DEF,
  parameter int D = D_DEF,
  localparam int IW = $clog2(D)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [ADDR_SPACE-1:0]    row_last,
  output logic [ADDR_SPACE-1:0]    sram_raddr,
  input  logic [D*BW-1:0]          sram_rdata,
  output logic                     sram_wsb,
  output logic [ADDR_SPACE-1:0]    sram_waddr,
  output logic [D-1:0]             sram_bytemask,
  output logic [D*BW-1:0]          sram_wdata,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [ADDR_SPACE+IW-1:0] out_vid,
  output logic [BW-2:0]            out_data,
  output logic                     busy,
  output logic                     done
);
  state_e state_q, state_d;
  logic [ADDR_SPACE-1:0] row_q, row_d, last_q, last_d;
  logic [IW-1:0] idx_q, idx_d;
  logic load, fire, step, last_row, fld_valid;
  logic [BW-2:0] fld_data;
  logic out_valid_q, out_valid_d;
  logic [ADDR_SPACE+IW-1:0] out_vid_q, out_vid_d;
  logic [BW-2:0] out_data_q, out_data_d;
  loc_field_mux #(.BW(BW), .D(D)) u_mux (
    .clk(clk), .load(load), .wdata(sram_rdata), .sel(idx_d), .valid(fld_valid), .payload(fld_data)
  );
  // sequencing: read, capture, scan every entry, optional write-back, then next row or finish
  always_comb begin
    state_d = state_q;
    row_d = row_q;
    last_d = last_q;
    idx_d = idx_q;
    load = 1'b0;
    fire = out_valid_q && out_ready;
    step = fire || !out_valid_q;
    last_row = row_q == last_q;
    case (state_q)
      IDLE: if (start) begin
        row_d = '0;
        last_d = row_last;
        state_d = RD;
      end
      RD: state_d = CAP;
      CAP: begin
        load = 1'b1;
        idx_d = '0;
        state_d = SCAN;
      end
      SCAN: if (step) begin
        idx_d = idx_q + 1'b1;
        if (idx_q == IW'(D - 1)) begin
`ifdef LOC_DRAIN_CLEAR_EN
          state_d = WB;
`else
          state_d = last_row ? DONE : RD;
          row_d = last_row ? row_q : row_q + 1'b1;
`endif
        end
      end
`ifdef LOC_DRAIN_CLEAR_EN
      WB: begin
        state_d = last_row ? DONE : RD;
        row_d = last_row ? row_q : row_q + 1'b1;
      end
`endif
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    out_valid_d = (state_d == SCAN) && fld_valid;
    out_vid_d = {row_q, idx_d};
    out_data_d = fld_data;
  end
  // control and stream output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      row_q <= '0;
      last_q <= '0;
      idx_q <= '0;
      out_valid_q <= 1'b0;
      out_vid_q <= '0;
      out_data_q <= '0;
    end else begin
      state_q <= state_d;
      row_q <= row_d;
      last_q <= last_d;
      idx_q <= idx_d;
      out_valid_q <= out_valid_d;
      out_vid_q <= out_vid_d;
      out_data_q <= out_data_d;
    end
  end
`ifdef LOC_DRAIN_CLEAR_EN
  logic [D-1:0] keep_q, keep_d;
  // keep mask in SRAM layout order: cleared for each entry handed downstream
  always_comb begin
    keep_d = keep_q;
    if (state_q == CAP) keep_d = '1;
    else if (state_q == SCAN && fire) keep_d[IW'(D - 1) - idx_q] = 1'b0;
  end
  // keep mask register
  always_ff @(posedge clk) keep_q <= rst ? '1 : keep_d;
  assign sram_wsb = state_q != WB;
  assign sram_bytemask = state_q == WB ? keep_q : '1;
`else
  assign sram_wsb = 1'b1;
  assign sram_bytemask = '1;
`endif
  assign sram_wdata = '0;
  assign sram_raddr = row_q;
  assign sram_waddr = row_q;
  assign out_valid = out_valid_q;
  assign out_vid = out_vid_q;
  assign out_data = out_data_q;
  assign busy = state_q != IDLE;
  assign done = state_q == DONE;
endmodule

// File: tb/tb_loc_sram_drain.sv
// tb_loc_sram_drain: directed vector bench for loc_sram_drain with a behavioural SRAM; honours LOC_DRAIN_CLEAR_EN
module tb_loc_sram_drain;
  localparam int A = 4;
  localparam int BW = 5;
  localparam int D = 256;
`ifdef LOC_DRAIN_CLEAR_EN
  localparam bit CLR = 1'b1;
`else
  localparam bit CLR = 1'b0;
`endif
  typedef struct {
    int pat; int pre; int rl; int stall; int restart;
    int nb; int v0; int d0; int v1; int d1;
    int done_c; int nwb; int wb_c; int mz;
  } vec_t;

  logic clk = 1'b0, rst = 1'b1, start = 1'b0, out_ready = 1'b1;
  logic [A-1:0] row_last = '0, sram_raddr, sram_waddr;
  logic [D*BW-1:0] sram_rdata = '0, sram_wdata;
  logic sram_wsb, out_valid, busy, done;
  logic [D-1:0] sram_bytemask;
  logic [A+7:0] out_vid;
  logic [BW-2:0] out_data;
  logic [D*BW-1:0] mem [16];
  logic pl_clr = 1'b0, pl_en = 1'b0;
  int pl_row = 0, pl_idx = 0;
  logic [BW-1:0] pl_val = '0;
  int cnt = 0, nvec = 0, nmis = 0;
  vec_t vt [5];

  loc_sram_drain dut (
    .clk(clk), .rst(rst), .start(start), .row_last(row_last),
    .sram_raddr(sram_raddr), .sram_rdata(sram_rdata), .sram_wsb(sram_wsb),
    .sram_waddr(sram_waddr), .sram_bytemask(sram_bytemask), .sram_wdata(sram_wdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_vid(out_vid), .out_data(out_data),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cnt <= cnt + 1;

  always @(posedge clk) begin
    sram_rdata <= mem[sram_raddr];
    if (pl_clr) begin
      for (int r = 0; r < 16; r++) mem[r] <= '0;
    end else if (pl_en) begin
      mem[pl_row][(D-1-pl_idx)*BW +: BW] <= pl_val;
    end else if (!sram_wsb) begin
      for (int i = 0; i < D; i++)
        if (!sram_bytemask[D-1-i]) mem[sram_waddr][(D-1-i)*BW +: BW] <= sram_wdata[(D-1-i)*BW +: BW];
    end
  end

  function automatic int fld(input int r, input int i);
    return int'(mem[r][(D-1-i)*BW +: BW]);
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nmis++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic preload(input int pat);
    @(negedge clk); pl_clr = 1'b1;
    @(negedge clk); pl_clr = 1'b0; pl_en = 1'b1;
    if (pat == 0) begin
      pl_row = 0; pl_idx = 3; pl_val = 5'b10110;
      @(negedge clk); pl_idx = 200; pl_val = 5'b11111;
      @(negedge clk);
    end else begin
      pl_row = 2; pl_idx = 0; pl_val = 5'b10001;
      @(negedge clk);
    end
    pl_en = 1'b0;
  endtask

  task automatic run(input string nm, input vec_t v);
    int base, cyc, stall, nb, nwb, wb_c, done_c, wd_bad;
    int bv [8];
    int bd [8];
    logic [D-1:0] fmask;
    if (v.pre != 0) preload(v.pat);
    @(negedge clk); start = 1'b1; row_last = A'(v.rl); base = cnt;
    @(negedge clk); start = 1'b0;
    stall = v.stall; nb = 0; nwb = 0; wb_c = -1; done_c = -1; wd_bad = 0; fmask = '1;
    for (int k = 0; k < 3000 && done_c < 0; k++) begin
      cyc = cnt - base;
      if (cyc == 1) chk({nm, "_busy_c1"}, int'(busy), 1);
      if (out_valid && stall > 0) begin
        out_ready = 1'b0;
        stall--;
        chk({nm, "_stall_vid"}, int'(out_vid), v.v0);
        chk({nm, "_stall_data"}, int'(out_data), v.d0);
      end else out_ready = 1'b1;
      if (out_valid && out_ready) begin
        if (nb < 8) begin bv[nb] = int'(out_vid); bd[nb] = int'(out_data); end
        nb++;
      end
      if (!sram_wsb) begin
        if (nwb == 0) begin wb_c = cyc; fmask = sram_bytemask; end
        if (sram_wdata != '0) wd_bad++;
        nwb++;
      end
      if (done) done_c = cyc;
      start = (v.restart != 0 && cyc == v.restart);
      @(negedge clk);
    end
    start = 1'b0; out_ready = 1'b1;
    chk({nm, "_idle_after_done"}, int'(busy), 0);
    chk({nm, "_done_cycle"}, done_c, v.done_c);
    chk({nm, "_beats"}, nb, v.nb);
    if (v.nb >= 1 && nb >= 1) begin
      chk({nm, "_vid0"}, bv[0], v.v0);
      chk({nm, "_data0"}, bd[0], v.d0);
    end
    if (v.nb >= 2 && nb >= 2) begin
      chk({nm, "_vid1"}, bv[1], v.v1);
      chk({nm, "_data1"}, bd[1], v.d1);
    end
    chk({nm, "_writes"}, nwb, v.nwb);
    chk({nm, "_wdata_nonzero"}, wd_bad, 0);
    if (v.nwb > 0) begin
      chk({nm, "_wb_cycle"}, wb_c, v.wb_c);
      chk({nm, "_mask_ones"}, $countones(fmask), D - v.mz);
      if (v.mz == 2) begin
        chk({nm, "_mask252"}, int'(fmask[252]), 0);
        chk({nm, "_mask55"}, int'(fmask[55]), 0);
      end
    end
    if (v.pat == 0) begin
      chk({nm, "_rb3"}, fld(0, 3), CLR ? 0 : 'h16);
      chk({nm, "_rb200"}, fld(0, 200), CLR ? 0 : 'h1f);
    end else begin
      chk({nm, "_rb512"}, fld(2, 0), CLR ? 0 : 'h11);
    end
  endtask

  initial begin
    int base, nlow;
    vec_t r;
    vt[0] = '{0, 1, 0, 0, 0, 2, 3, 6, 200, 15, CLR ? 260 : 259, CLR ? 1 : 0, 259, 2};
    vt[1] = '{0, 1, 0, 5, 0, 2, 3, 6, 200, 15, CLR ? 265 : 264, CLR ? 1 : 0, 264, 2};
    vt[2] = '{1, 1, 2, 0, 0, 1, 512, 1, 0, 0, CLR ? 778 : 775, CLR ? 3 : 0, 259, 0};
    vt[3] = '{0, 1, 0, 0, 50, 2, 3, 6, 200, 15, CLR ? 260 : 259, CLR ? 1 : 0, 259, 2};
    vt[4] = '{0, 0, 0, 0, 0, CLR ? 0 : 2, 3, 6, 200, 15, CLR ? 260 : 259, CLR ? 1 : 0, 259, CLR ? 0 : 2};
    r = '{0, 0, 0, 0, 0, 2, 3, 6, 200, 15, CLR ? 260 : 259, CLR ? 1 : 0, 259, 2};
    repeat (3) @(negedge clk);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_wsb", int'(sram_wsb), 1);
    chk("rst_mask_ones", $countones(sram_bytemask), D);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) run($sformatf("vec%0d", i), vt[i]);
    preload(0);
    @(negedge clk); start = 1'b1; row_last = '0; base = cnt;
    @(negedge clk); start = 1'b0;
    while (cnt - base < 100) @(negedge clk);
    chk("mid_busy_c100", int'(busy), 1);
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    chk("mid_rst_out_valid", int'(out_valid), 0);
    chk("mid_rst_wsb", int'(sram_wsb), 1);
    chk("mid_rst_mask_ones", $countones(sram_bytemask), D);
    chk("mid_rst_wdata", int'(sram_wdata != '0), 0);
    chk("mid_rst_raddr", int'(sram_raddr), 0);
    chk("mid_rst_waddr", int'(sram_waddr), 0);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_done", int'(done), 0);
    nlow = 0;
    repeat (300) begin
      @(negedge clk);
      if (!sram_wsb) nlow++;
    end
    chk("mid_rst_no_write", nlow, 0);
    run("after_rst", r);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule

// File: doc/loc_sram_drain.md
# loc_sram_drain

Read-side engine for the 16x1280b location SRAM (16 rows × 256 entries × 5 bits, entry = {valid, 4-bit payload}). On `start` it reads rows `0..row_last`, scans every entry, emits each valid one as a (vid, payload) beat on a valid/ready stream, then writes the row back with the emitted entries cleared. It owns the SRAM read port and write port while `busy`, and feeds the downstream graph-update logic.

## Interface
- `ADDR_SPACE`, 4: SRAM row address width (16 rows).
- `BW`, 5: entry width; bit BW-1 is the valid bit, bits BW-2:0 are the payload.
- `D`, 256: entries per row.
- `clk`  in  1  clock; all logic on posedge.
- `rst`  in  1  reset; synchronous, active-high.
- `start`  in  1  one-cycle pulse; accepted only in IDLE.
- `row_last`  in  ADDR_SPACE  last row to drain; sampled with `start`.
- `sram_raddr`  out  ADDR_SPACE  SRAM read address.
- `sram_rdata`  in  D*BW  SRAM read data; valid 1 cycle after `sram_raddr`.
- `sram_wsb`  out  1  SRAM write enable, active-low.
- `sram_waddr`  out  ADDR_SPACE  SRAM write address.
- `sram_bytemask`  out  D  per-entry mask; 1 = keep the old value.
- `sram_wdata`  out  D*BW  SRAM write data.
- `out_valid`  out  1  stream beat valid.
- `out_ready`  in  1  stream beat accepted.
- `out_vid`  out  ADDR_SPACE+8  vertex id, computed as row*D + idx.
- `out_data`  out  BW-1  entry payload.
- `busy`  out  1  high from the cycle after `start` until DONE inclusive.
- `done`  out  1  one-cycle pulse after the last row.

## Operation
- Entry layout: entry idx occupies `rdata[(D-1-idx)*BW +: BW]` and `bytemask[D-1-idx]`. Entry idx 0 is therefore the most significant field.
- States and transitions:
  - IDLE: `start` loads row=0 and captures `row_last`; go to RD.
  - RD: drive `sram_raddr`=row; go to CAP.
  - CAP: register `sram_rdata` into the row buffer; clear idx and the emitted mask; go to SCAN.
  - SCAN, entry idx invalid: idx++ in one cycle.
  - SCAN, entry idx valid: hold `out_valid`=1 with stable vid and payload until `out_ready`. On the handshake, set emitted[idx] and idx++.
  - SCAN exit: after idx=D-1 completes, go to WB. Without the clear feature, go directly to the next-row decision.
  - WB: one cycle with `sram_wsb`=0, `sram_waddr`=row, `sram_wdata`=0, `sram_bytemask`=~emitted (bit-reversed to the layout above). The write is issued even when no entries were emitted; the mask is then all ones.
  - Next-row decision: if row==row_last go to DONE, otherwise row++ and go to RD.
  - DONE: `done`=1 for one cycle; go to IDLE.
- Only emitted entries are overwritten; all other entries keep their value.
- `start` while `busy` is ignored.
- `row_last`=15 drains all 16 rows. The row counter never wraps.
- Reset values: `out_valid`=0, `sram_wsb`=1, `sram_bytemask`=all ones, `sram_wdata`=0, `sram_raddr`=0, `sram_waddr`=0, `busy`=0, `done`=0, state IDLE.
- Reset mid-operation: all outputs take their reset values on the next edge. No write is issued. A pending beat is dropped.

## Timing
- `start` at edge 0 puts RD in cycle 1, CAP in cycle 2 and SCAN in cycles 3..258 (no stalls).
- With the clear feature: WB in cycle 259. The next row's RD follows in cycle 260.
- Row period with no backpressure is 259 cycles with the clear feature, 258 without. Each cycle of `out_ready` low adds one cycle.
- `done` is asserted in cycle 1 + N_rows × period.
- `out_vid` and `out_data` are registered. They change only after a handshake or when entering a new idx.

## Configuration
- Macro: `LOC_DRAIN_CLEAR_EN`.
- Defined: WB state present; emitted entries are zeroed in the SRAM.
- Undefined: no WB state. `sram_wsb` stays 1, `sram_bytemask` stays all ones and `sram_wdata` stays 0 permanently. A repeated drain re-emits the same entries.

## Structure
- Package `loc_drain_pkg`:
  - state enum (IDLE, RD, CAP, SCAN, WB, DONE);
  - default ADDR_SPACE/BW/D;
  - field-offset function mapping idx to `(D-1-idx)*BW`.
- Sub-module `loc_field_mux`: row buffer plus idx-indexed extraction of {valid, payload}.

## Test plan
- Row 0 holds vid 3 = 5'b10110 and vid 200 = 5'b11111; row_last=0; `out_ready`=1. Expect:
  - beats (3, 4'h6) then (200, 4'hF);
  - WB in cycle 259 with bytemask bits 252 and 55 low;
  - both fields read back 0;
  - `done` in cycle 260.
- Same setup with `out_ready` low for 5 cycles while vid 3 is presented. Expect `out_valid`, `out_vid` and `out_data` held stable, and `done` in cycle 265.
- Rows 0 and 1 empty; row 2 holds vid 0 = 5'b10001; row_last=2. Expect a single beat (512, 4'h1) and `done` in cycle 778.
- `rst` pulsed in cycle 100 (inside SCAN). Expect all outputs at reset values next cycle and no `sram_wsb` low. A new `start` re-emits the row-0 entries.
- `start` pulsed again during SCAN: ignored, timing unchanged. Build without `LOC_DRAIN_CLEAR_EN`: `sram_wsb` never low, `done` in cycle 259, and a second drain emits identical beats.
